// File: rtl/sysclk_bitcommand_sched.sv
// sysclk_bitcommand_sched: collects one-shot bit requests and issues them once per SYSCLK command period
// at the phase-1 evaluation point, with sync alignment, per-bit holdoff, overflow flags and an issue count.
module sysclk_bitcommand_sched #(
    parameter int               NBITS           = 8,
    parameter logic [NBITS-1:0] SYNC_ALIGN_MASK = NBITS'(1),
    parameter int               HOLDOFF         = 2
) (
    input  logic             sysclk_i,
    input  logic             sysclk_rst_i,
    input  logic             sysclk_phase_i,
    input  logic             sysclk_sync_i,
    input  logic [NBITS-1:0] req_i,
    input  logic [NBITS-1:0] enable_i,
    input  logic             clr_i,
    output logic [NBITS-1:0] bitcommand_o,
    output logic [NBITS-1:0] ack_o,
    output logic [NBITS-1:0] overflow_o,
    output logic [15:0]      issue_count_o
);
    localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    logic [NBITS-1:0] req_q;
    logic [NBITS-1:0] pending;
    logic [NBITS-1:0] req_edge;
    logic [NBITS-1:0] hold_zero;
    logic [NBITS-1:0] issue;
    logic             phase_1;
    logic [HW-1:0]    hold [NBITS];

    assign req_edge = req_i & ~req_q;

    always_comb begin
        hold_zero = '0;
        for (int b = 0; b < NBITS; b++) hold_zero[b] = (hold[b] == '0);
        issue = phase_1 ? (pending & hold_zero & (~SYNC_ALIGN_MASK | {NBITS{sysclk_sync_i}})) : '0;
    end

    // req_q loads through reset so a level held across reset is not seen as a new request
    always_ff @(posedge sysclk_i) begin
        req_q <= req_i;
        if (sysclk_rst_i) begin
            phase_1       <= 1'b0;
            pending       <= '0;
            bitcommand_o  <= '0;
            ack_o         <= '0;
            overflow_o    <= '0;
            issue_count_o <= '0;
            for (int b = 0; b < NBITS; b++) hold[b] <= '0;
        end else begin
            phase_1    <= sysclk_phase_i;
            pending    <= enable_i & (req_edge | (pending & ~issue));
            overflow_o <= (req_edge & enable_i & pending & ~issue) | (overflow_o & ~{NBITS{clr_i}});
            ack_o      <= issue;
            if (phase_1) begin
                bitcommand_o <= issue;
                if (|issue) issue_count_o <= issue_count_o + 16'd1;
                for (int b = 0; b < NBITS; b++)
                    hold[b] <= issue[b] ? HW'(HOLDOFF) : (hold_zero[b] ? '0 : hold[b] - HW'(1));
            end
        end
    end
endmodule

// File: doc/sysclk_bitcommand_sched.md
# sysclk_bitcommand_sched

Scheduler and arbiter for the shared SYSCLK bitcommand word. It collects one-shot command requests from up to NBITS independent requesters, holds each pending, and issues it once per command period at the fixed phase-1 evaluation point. Bits in SYNC_ALIGN_MASK are issued only when SYSCLK sync is high. The registered output drives the command encoder, which captures late in the period; the block adds per-bit re-issue holdoff, overflow flags and an issue counter.

## Interface
- NBITS, 8: width of bitcommand word; one requester per bit
- SYNC_ALIGN_MASK, 8'h01: bits that may only issue when sysclk_sync_i is high at evaluation
- HOLDOFF, 2: command periods a bit is blocked after issuing (0 = none)

- sysclk_i  in  1  SYSCLK; sole clock
- sysclk_rst_i  in  1  reset, synchronous, active-high
- sysclk_phase_i  in  1  one-cycle pulse marking phase 0 of each command period
- sysclk_sync_i  in  1  SYSCLK sync level
- req_i  in  NBITS  per-bit request, synchronous to sysclk_i; a rising edge is one request
- enable_i  in  NBITS  per-bit enable; low drops new requests and clears pending
- clr_i  in  1  clears overflow_o
- bitcommand_o  out  NBITS  registered bitcommand word, held for a full command period
- ack_o  out  NBITS  one-cycle pulse per bit on the cycle its command appears on bitcommand_o
- overflow_o  out  NBITS  sticky: request edge arrived while already pending
- issue_count_o  out  16  count of command periods with nonzero bitcommand_o, wraps

## Operation
- Edge detect: req_q <= req_i every cycle. During reset req_q also loads req_i, so a level held high through reset produces no edge. edge = req_i & ~req_q.
- Pending per bit: set on edge & enable_i. Cleared on issue or when enable_i is low. Set wins over issue-clear in the same cycle, so a new request arriving at the issue edge is kept and is not an overflow.
- Overflow: set when edge & enable_i & pending & ~issue. Requests merge; no queueing. clr_i clears overflow. If clr_i and a new overflow occur together, set wins.
- phase_1 <= sysclk_phase_i. The evaluation cycle is phase_1 = 1.
- At evaluation, per bit: issue = pending & (hold == 0) & (~SYNC_ALIGN_MASK | {NBITS{sysclk_sync_i}}).
- At evaluation, bitcommand_o <= issue (zeros for non-issued bits). It is held until the next evaluation.
- ack_o <= issue at evaluation; ack_o is 0 on every other cycle.
- Holdoff counter per bit, width $clog2(HOLDOFF+1). At evaluation: if issue, load HOLDOFF; else if nonzero, decrement. After an issue in period P, the earliest re-issue is period P+HOLDOFF+1.
- A blocked bit (holdoff or sync misaligned) stays pending and is retried every period. No starvation: all eligible bits issue together, with no priority between bits.
- issue_count_o increments at evaluation when issue != 0. 0xFFFF wraps to 0.
- Reset values: bitcommand_o 0, ack_o 0, overflow_o 0, issue_count_o 0, pending 0, holdoff 0, phase_1 0. Reset mid-period discards all pending requests. Reset dominates all other inputs.

## Timing
- Cycle n: sysclk_phase_i = 1. Cycle n+1: evaluation. Edge n+2: bitcommand_o and ack_o update.
- A request edge sampled at edge k sets pending at edge k. It is eligible at an evaluation edge e if k ≤ e−1. An edge sampled at e itself waits for the next period.
- Best-case latency from req_i rise to bitcommand_o: 1 cycle (req rises right before evaluation). Worst case: one command period plus 1 cycle.
- sysclk_sync_i is sampled only at the evaluation edge.
- Back-to-back sysclk_phase_i pulses are legal; each one is an evaluation.

## Test plan
- Period 8 cycles, bit 3 request edge 3 cycles before evaluation → bitcommand_o = 8'h08 for exactly 8 cycles; ack_o[3] pulses once, aligned with bitcommand_o rising; issue_count_o = 1.
- Bit 0 requested while sysclk_sync_i is low for 2 evaluations, then high → bit 0 issues only in the third period; pending is retained throughout.
- HOLDOFF = 2, bit 1 re-requested every cycle → bit 1 issues in periods 0, 3, 6; overflow_o[1] is set; clr_i clears it.
- Bits 2 and 5 requested in the same period, bit 5 disabled before evaluation → bitcommand_o = 8'h04; bit 5 is never issued.
- New edge on bit 4 exactly at its issue edge → issued this period and again next period (HOLDOFF = 0); no overflow.
- req_i held 8'hFF through sysclk_rst_i, reset asserted mid-period with requests pending → after reset, all outputs are 0 and no command issues; issue_count_o wraps from 0xFFFF to 0 on the next issue.
